// File: rtl/ps2_rx_frontend_pkg.sv
// Shared constants and types for the PS/2 receive front-end.
// Prefix byte values, receiver state encoding and the frame parity helper.
package ps2_rx_frontend_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

   typedef enum logic [1:0] {
      PS2RX_IDLE   = 2'd0,
      PS2RX_DATA   = 2'd1,
      PS2RX_PARITY = 2'd2,
      PS2RX_STOP   = 2'd3
   } ps2_rx_state_t;

   // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_frontend_if.sv
// Scan-event bus from the PS/2 receive front-end to the key translator.
// master drives the events, slave consumes them.
interface ps2_rx_frontend_if;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       scan_ext;
   logic       scan_release;
   logic       frame_err;
   logic       busy;

   modport master (
      output scan_valid,
      output scan_code,
      output scan_ext,
      output scan_release,
      output frame_err,
      output busy
   );

   modport slave (
      input scan_valid,
      input scan_code,
      input scan_ext,
      input scan_release,
      input frame_err,
      input busy
   );
endinterface

// File: rtl/ps2_rx_frontend_line_filter.sv
// Pin conditioning for the PS/2 receiver: two-flop synchronisers, a
// FILTER_LEN-sample glitch filter on the clock line and a registered fall pulse.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ps2_clk,
   input  logic i_ps2_dat,
   output logic o_dat,
   output logic o_clk_filt,
   output logic o_fall
);

   logic [1:0]            r_clk_sync;
   logic [1:0]            r_dat_sync;
   logic [FILTER_LEN-1:0] r_hist;
   logic                  r_clk_filt;
   logic                  r_fall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_hist     <= '1;
         r_clk_filt <= 1'b1;
         r_fall     <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
         r_hist     <= {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
         r_fall     <= 1'b0;
         // The filtered level only flips once the whole history window agrees.
         if (r_hist == '0) begin
            r_clk_filt <= 1'b0;
            r_fall     <= r_clk_filt;
         end else if (r_hist == '1) begin
            r_clk_filt <= 1'b1;
         end
      end
   end

   assign o_dat      = r_dat_sync[1];
   assign o_clk_filt = r_clk_filt;
   assign o_fall     = r_fall;

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: frame deserialiser, inter-edge timeout and
// E0/F0 prefix folding, delivering one strobed scan event per key.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (dat=0 on a fall)
// DATA   | shifting in eight data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then byte done or frame error
module ps2_rx_frontend
   import ps2_rx_frontend_pkg::*;
#(
   parameter int CLK_FREQ   = 28_000_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 1000
) (
   input  logic               i_clk28,
   input  logic               i_rst,
   input  logic               i_ps2_clk_in,
   input  logic               i_ps2_dat_in,
   ps2_rx_frontend_if.master  o_scan
);

   localparam int TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int TMO_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ST_IDLE   = PS2RX_IDLE;
   localparam logic [1:0] ST_DATA   = PS2RX_DATA;
   localparam logic [1:0] ST_PARITY = PS2RX_PARITY;
   localparam logic [1:0] ST_STOP   = PS2RX_STOP;

   logic             w_dat;
   logic             w_clk_filt;
   logic             w_fall_raw;
   logic             w_fall;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shreg;
   logic             r_parity_ok;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_byte_done;
   logic             w_err;
   logic             w_is_ext;
   logic             w_is_rel;

   logic             r_ext_pending;
   logic             r_rel_pending;
   logic             r_scan_valid;
   logic [7:0]       r_scan_code;
   logic             r_scan_ext;
   logic             r_scan_release;
   logic             r_frame_err;
   logic             r_busy;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_line_filter (
      .i_clk      (i_clk28),
      .i_rst      (i_rst),
      .i_ps2_clk  (i_ps2_clk_in),
      .i_ps2_dat  (i_ps2_dat_in),
      .o_dat      (w_dat),
      .o_clk_filt (w_clk_filt),
      .o_fall     (w_fall_raw)
   );

   assign w_fall   = w_fall_raw & ~w_clk_filt;
   assign w_is_ext = (r_shreg == PS2_PREFIX_EXT);
   assign w_is_rel = (r_shreg == PS2_PREFIX_REL);

   // A fall in the expiry cycle takes priority, so a late-but-valid edge is not an error.
   always_comb begin
      w_state_nxt = r_state;
      w_byte_done = 1'b0;
      w_err       = 1'b0;
      if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_dat) w_state_nxt = ST_DATA;
               else        w_err       = 1'b1;
            end
            ST_DATA: begin
               if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
               w_state_nxt = ST_STOP;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               if (w_dat && r_parity_ok) w_byte_done = 1'b1;
               else                      w_err       = 1'b1;
            end
         endcase
      end else if (r_state != ST_IDLE && r_tmo_cnt == TMO_LAST) begin
         w_state_nxt = ST_IDLE;
         w_err       = 1'b1;
      end
   end

   always_ff @(posedge i_clk28) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_bitcnt    <= 3'd0;
         r_shreg     <= 8'h00;
         r_parity_ok <= 1'b0;
         r_tmo_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         if (w_fall) begin
            case (r_state)
               ST_IDLE: r_bitcnt <= 3'd0;
               ST_DATA: begin
                  r_shreg  <= {w_dat, r_shreg[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               ST_PARITY: r_parity_ok <= ps2_odd_parity_ok(r_shreg, w_dat);
               default: ;
            endcase
         end
         if (w_fall || r_state == ST_IDLE) r_tmo_cnt <= '0;
         else if (r_tmo_cnt != TMO_LAST)   r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end

   always_ff @(posedge i_clk28) begin
      if (i_rst) begin
         r_ext_pending  <= 1'b0;
         r_rel_pending  <= 1'b0;
         r_scan_valid   <= 1'b0;
         r_scan_code    <= 8'h00;
         r_scan_ext     <= 1'b0;
         r_scan_release <= 1'b0;
         r_frame_err    <= 1'b0;
      end else begin
         r_frame_err  <= w_err;
         r_scan_valid <= w_byte_done & ~w_is_ext & ~w_is_rel;
         if (w_err) begin
            r_ext_pending <= 1'b0;
            r_rel_pending <= 1'b0;
         end else if (w_byte_done) begin
            if (w_is_ext) begin
               r_ext_pending <= 1'b1;
            end else if (w_is_rel) begin
               r_rel_pending <= 1'b1;
            end else begin
               r_scan_code    <= r_shreg;
               r_scan_ext     <= r_ext_pending;
               r_scan_release <= r_rel_pending;
               r_ext_pending  <= 1'b0;
               r_rel_pending  <= 1'b0;
            end
         end
      end
   end

   assign o_scan.scan_valid   = r_scan_valid;
   assign o_scan.scan_code    = r_scan_code;
   assign o_scan.scan_ext     = r_scan_ext;
   assign o_scan.scan_release = r_scan_release;
   assign o_scan.frame_err    = r_frame_err;
   assign o_scan.busy         = r_busy;

endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
PS/2 receive front-end that sits directly upstream of the PS/2 keyboard-to-ZX-matrix translator.
- Synchronises and de-glitches the raw ps2_clk/ps2_dat pins.
- Deserialises 11-bit device-to-host frames and checks start, parity and stop bits.
- Folds the E0/F0 prefix bytes into flags, then delivers one strobed scan code per key event.
- Runs entirely on clk28; transmit (host-to-device) is out of scope.

Parameters:
CLK_FREQ, 28_000_000, system clock frequency in Hz
FILTER_LEN, 8, number of consecutive equal synchronised clk28 samples needed to change the filtered ps2 clock
TIMEOUT_US, 1000, maximum gap between PS/2 clock falling edges inside a frame, in µs; TIMEOUT_CYC = CLK_FREQ/1_000_000*TIMEOUT_US

Ports:
clk28  in  1  system clock, 28 MHz
rst  in  1  reset; one clock, synchronous, active-high
ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous
ps2_dat_in  in  1  raw PS/2 data pin, asynchronous
scan_valid  out  1  one-cycle strobe: new scan event present
scan_code  out  8  scan code byte; held until next scan_valid
scan_ext  out  1  E0 prefix preceded this code; held with scan_code
scan_release  out  1  F0 prefix preceded this code; held with scan_code
frame_err  out  1  one-cycle strobe: start/parity/stop error or timeout
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: scan_valid, frame_err, busy = 0; scan_code = 8'h00; scan_ext, scan_release = 0; state IDLE; filter history all ones (idle-high line); ext/rel pendings 0; timeout counter 0. Reset mid-frame aborts the frame with no strobe of any kind.
- Input conditioning:
  - Two-flop synchroniser on each pin.
  - Filtered clk goes low only after FILTER_LEN consecutive low samples, and high only after FILTER_LEN consecutive high samples.
  - Falling edge of filtered clk gives a registered one-cycle fall pulse.
  - Data is the synchronised ps2_dat sampled in the fall-pulse cycle.
- FSM (states IDLE, DATA, PARITY, STOP; advances only on fall):
  - IDLE: dat=0 → DATA, bitcnt=0. dat=1 → stay IDLE, pulse frame_err.
  - DATA: shift dat in LSB-first; after 8th bit → PARITY.
  - PARITY: store bit; parity_ok = ^{data,parity} == 1 (odd parity) → STOP.
  - STOP: dat=1 and parity_ok → byte done; otherwise pulse frame_err. Always → IDLE.
- Timeout:
  - Counter clears on every fall and whenever state is IDLE; otherwise increments, saturating.
  - Reaching TIMEOUT_CYC → IDLE, frame_err pulse, pendings cleared.
  - A fall in the same cycle as expiry wins: counter clears, no error.
- Prefix layer on byte done:
  - 8'hE0 → ext_pending=1, no strobe.
  - 8'hF0 → rel_pending=1, no strobe.
  - Any other byte (including E1, AA, FA, FE) → scan_valid pulse. scan_code = byte, scan_ext = ext_pending, scan_release = rel_pending; then both pendings clear.
  - Every frame_err also clears both pendings.
- Latency: scan_valid and frame_err are asserted the clk28 cycle after the fall pulse of the stop bit (or after timeout expiry). scan_code/flags update in that same cycle.
- scan_valid and frame_err are never high together.
- busy = (state != IDLE), registered with state.

Decomposition:
- Shared package (common):
  - PS2_PREFIX_EXT = 8'hE0
  - PS2_PREFIX_REL = 8'hF0
  - enum ps2_rx_state_t {PS2RX_IDLE, PS2RX_DATA, PS2RX_PARITY, PS2RX_STOP}
- One sub-module: ps2_line_filter. Contains the two-flop synchronisers, the FILTER_LEN glitch filter and the fall-edge pulse. Outputs: synchronised dat, filtered clk, fall pulse.
- The top of the block holds the FSM, timeout counter and prefix logic.

Test Plan:
1. Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), 80 µs clock period → exactly one scan_valid; scan_code=1C, ext=0, release=0; frame_err never high; busy drops after stop.
2. Frames F0,1C → single strobe: code=1C, release=1, ext=0. Then E0,F0,75 → single strobe: code=75, ext=1, release=1. Then 1C → ext=0, release=0.
3. 0x1C with parity bit=1 → frame_err pulse, no scan_valid. Stop bit=0 on a valid frame → frame_err. Next good frame 0x29 → code=29.
4. Idle line, 3-cycle low glitch on ps2_clk_in (< FILTER_LEN); also a 3-cycle glitch mid-bit → no fall, state/bitcnt unchanged, busy=0 at idle; following frame decodes correctly.
5. TIMEOUT_US=10: send E0, then start + 4 data bits, then stop clocking → frame_err exactly 280 cycles after last fall; busy→0. Next 0x1C → ext=0, proving pending was cleared.
6. Assert rst for 1 cycle after 5 data bits → all outputs 0 the next cycle, no strobe. Full frame 0x29 then → scan_valid, code=29.
